board_cmd_unit: RTL and testbench

Downstream consumer of the message queue in the vine-sweeper datapath. Pops encoded player commands (reveal, flag, clear) from the queue and applies each one to an internal minesweeper cell array. For each safe cell it reveals, it counts the mines in the surrounding cells one neighbour per cycle. Exposes a registered cell-readout port plus game status flags to the display logic.

---
 rtl/board_cmd_unit.sv | 184 ++++++++++++++++++
 tb/tb_board_cmd_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_cmd_unit.sv
// Minesweeper board engine: pops encoded commands from the message queue, applies
// them to an N x N cell array and counts neighbour mines one neighbour per cycle.
module board_cmd_unit #(
    parameter int COORD_BITS = 3,
    parameter int MSG_W      = 2 + 2*COORD_BITS
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [(1<<(2*COORD_BITS))-1:0]  mine_map,
    input  logic [MSG_W-1:0]                read,
    input  logic                            read_en,
    output logic                            read_ack,
    input  logic [COORD_BITS-1:0]           rd_x,
    input  logic [COORD_BITS-1:0]           rd_y,
    output logic [5:0]                      rd_cell,
    output logic [2*COORD_BITS:0]           revealed_count,
    output logic                            busy,
    output logic                            game_over,
    output logic                            game_won,
    output logic [2:0]                      dbg_state
);
    localparam int CB    = COORD_BITS;
    localparam int IW    = 2*COORD_BITS;
    localparam int CELLS = 1 << IW;
    localparam logic [IW:0]   CELLS_W = (IW+1)'(CELLS);
    localparam logic [CB+1:0] OFF_M1  = '1;
    localparam logic [CB+1:0] OFF_Z   = '0;
    localparam logic [CB+1:0] OFF_P1  = {{(CB+1){1'b0}}, 1'b1};
    localparam logic [1:0] OP_NOP = 2'b00, OP_REVEAL = 2'b01, OP_FLAG = 2'b10, OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {SWEEP, REQ, WAIT, EXEC, SCAN, WRITE} state_t;

    state_t           state, next_state;
    logic [5:0]       cells [CELLS];
    logic [CELLS-1:0] mine_q;
    logic [IW-1:0]    idx;
    logic [IW:0]      mine_total;
    logic [MSG_W-1:0] cmd;
    logic [2:0]       k;
    logic [3:0]       acc;

    logic [1:0]       cmd_op;
    logic [CB-1:0]    cmd_x, cmd_y;
    logic [IW-1:0]    cmd_idx;
    logic [5:0]       cur_cell;
    logic             cur_mine, locked, do_flag, do_boom, go_scan;
    logic [CB+1:0]    ox, oy, nx, ny;
    logic             nb_valid, mine_hit;
    logic [IW:0]      rc_next;

    assign cmd_op   = cmd[MSG_W-1 -: 2];
    assign cmd_x    = cmd[2*CB-1:CB];
    assign cmd_y    = cmd[CB-1:0];
    assign cmd_idx  = {cmd_y, cmd_x};
    assign cur_cell = cells[cmd_idx];
    assign cur_mine = mine_q[cmd_idx];
    assign locked   = game_over || game_won;
    assign do_flag  = (state == EXEC) && (cmd_op == OP_FLAG) && !locked && !cur_cell[4];
    assign do_boom  = (state == EXEC) && (cmd_op == OP_REVEAL) && !locked
                      && !cur_cell[4] && !cur_cell[5] && cur_mine;
    assign go_scan  = (state == EXEC) && (cmd_op == OP_REVEAL) && !locked
                      && !cur_cell[4] && !cur_cell[5] && !cur_mine;
    assign rc_next  = revealed_count + 1'b1;

    // Neighbour k as an offset; the two extra top bits flag off-board coordinates.
    always_comb begin
        ox = OFF_Z;
        oy = OFF_Z;
        case (k)
            3'd0: begin ox = OFF_M1; oy = OFF_M1; end
            3'd1: begin ox = OFF_Z;  oy = OFF_M1; end
            3'd2: begin ox = OFF_P1; oy = OFF_M1; end
            3'd3: begin ox = OFF_M1; oy = OFF_Z;  end
            3'd4: begin ox = OFF_P1; oy = OFF_Z;  end
            3'd5: begin ox = OFF_M1; oy = OFF_P1; end
            3'd6: begin ox = OFF_Z;  oy = OFF_P1; end
            default: begin ox = OFF_P1; oy = OFF_P1; end
        endcase
        nx       = {2'b00, cmd_x} + ox;
        ny       = {2'b00, cmd_y} + oy;
        nb_valid = (nx[CB+1:CB] == 2'b00) && (ny[CB+1:CB] == 2'b00);
        mine_hit = nb_valid && mine_q[{ny[CB-1:0], nx[CB-1:0]}];
    end

    always_ff @(posedge clock) begin
        if (reset) state <= SWEEP;
        else       state <= next_state;
    end

    // Queue handshake: read_ack pulses in REQ; the queue answers in the following
    // WAIT cycle, where read is taken only if read_en is high, otherwise we re-request.
    always_comb begin
        next_state = state;
        read_ack   = 1'b0;
        busy       = 1'b1;
        case (state)
            SWEEP: if (&idx) next_state = REQ;
            REQ: begin
                read_ack   = 1'b1;
                busy       = 1'b0;
                next_state = WAIT;
            end
            WAIT: begin
                busy       = 1'b0;
                next_state = read_en ? EXEC : REQ;
            end
            EXEC: begin
                if (cmd_op == OP_CLEAR) next_state = SWEEP;
                else if (go_scan)       next_state = SCAN;
                else                    next_state = REQ;
            end
            SCAN:    if (k == 3'd7) next_state = WRITE;
            WRITE:   next_state = REQ;
            default: next_state = SWEEP;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            idx            <= '0;
            mine_total     <= '0;
            cmd            <= '0;
            k              <= '0;
            acc            <= '0;
            game_over      <= 1'b0;
            game_won       <= 1'b0;
            revealed_count <= '0;
        end else begin
            case (state)
                SWEEP: begin
                    mine_total <= mine_total + (IW+1)'(mine_map[idx]);
                    idx        <= idx + 1'b1;
                    if (&idx) begin
                        game_over      <= 1'b0;
                        game_won       <= 1'b0;
                        revealed_count <= '0;
                    end
                end
                WAIT: if (read_en) cmd <= read;
                EXEC: begin
                    k   <= '0;
                    acc <= '0;
                    if (cmd_op == OP_CLEAR) begin
                        idx        <= '0;
                        mine_total <= '0;
                    end
                    if (do_boom) game_over <= 1'b1;
                end
                SCAN: begin
                    acc <= acc + {3'b000, mine_hit};
                    k   <= k + 3'd1;
                end
                WRITE: begin
                    revealed_count <= rc_next;
                    if (rc_next == CELLS_W - mine_total) game_won <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Cell array and mine copy need no reset: a sweep always follows reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == SWEEP) begin
                cells[idx]  <= '0;
                mine_q[idx] <= mine_map[idx];
            end else if (do_flag) begin
                cells[cmd_idx] <= {~cur_cell[5], cur_cell[4:0]};
            end else if (do_boom) begin
                cells[cmd_idx] <= {cur_cell[5], 1'b1, cur_cell[3:0]};
            end else if (state == WRITE) begin
                cells[cmd_idx] <= {1'b0, 1'b1, acc};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) rd_cell <= '0;
        else       rd_cell <= cells[{rd_y, rd_x}];
    end
endmodule

// File: tb/tb_board_cmd_unit.sv
// Bench for board_cmd_unit: directed scenarios plus randomized command streams,
// checked against a behavioural board model kept in plain arrays.
module tb_board_cmd_unit;
    localparam int CB    = 3;
    localparam int N     = 8;
    localparam int CELLS = 64;
    localparam int MSG_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [CELLS-1:0] mine_map = '0;
    logic [MSG_W-1:0] read = '0;
    logic             read_en = 1'b0;
    logic             read_ack;
    logic [CB-1:0]    rd_x = '0, rd_y = '0;
    logic [5:0]       rd_cell;
    logic [2*CB:0]    revealed_count;
    logic             busy, game_over, game_won;
    logic [2:0]       dbg_state;

    board_cmd_unit #(.COORD_BITS(CB), .MSG_W(MSG_W)) dut (
        .clock(clock), .reset(reset), .mine_map(mine_map), .read(read),
        .read_en(read_en), .read_ack(read_ack), .rd_x(rd_x), .rd_y(rd_y),
        .rd_cell(rd_cell), .revealed_count(revealed_count), .busy(busy),
        .game_over(game_over), .game_won(game_won), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clock = ~clock;
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    logic prev_ack = 1'b0;
    always @(negedge clock) begin
        if (read_ack) check("ack_gap", 32'(prev_ack), 32'd0);
        prev_ack <= read_ack;
    end

    // reference model
    bit m_mine[CELLS], m_rev[CELLS], m_flag[CELLS];
    int m_cnt[CELLS];
    int m_rc, m_total;
    bit m_over, m_won;

    function automatic void model_clear();
        m_total = 0;
        for (int i = 0; i < CELLS; i++) begin
            m_mine[i] = mine_map[i];
            m_rev[i]  = 0;
            m_flag[i] = 0;
            m_cnt[i]  = 0;
            m_total  += int'(mine_map[i]);
        end
        m_rc = 0;
        m_over = 0;
        m_won = 0;
    endfunction

    function automatic int nb_mines(int x, int y);
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if ((dx != 0 || dy != 0) && x+dx >= 0 && x+dx < N && y+dy >= 0 && y+dy < N)
                    n += int'(m_mine[(y+dy)*N + (x+dx)]);
        return n;
    endfunction

    // Applies one command to the model; returns cycles from the accepting WAIT to next read_ack.
    function automatic int model_apply(int op, int x, int y);
        int i = y*N + x;
        if (op == 0) return 2;
        if (op == 3) begin
            model_clear();
            return CELLS + 2;
        end
        if (m_over || m_won) return 2;
        if (op == 2) begin
            if (!m_rev[i]) m_flag[i] = !m_flag[i];
            return 2;
        end
        if (m_rev[i] || m_flag[i]) return 2;
        m_rev[i] = 1;
        if (m_mine[i]) begin
            m_over = 1;
            return 2;
        end
        m_cnt[i] = nb_mines(x, y);
        m_rc++;
        if (m_rc == CELLS - m_total) m_won = 1;
        return 3 + 8;
    endfunction

    // driver tasks (all start and end at a negedge where read_ack is high)
    task automatic sync_ack();
        int n = 0;
        while (!read_ack && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!read_ack) check("ack_timeout", 32'(read_ack), 32'd1);
    endtask

    task automatic send(input int op, input int x, input int y);
        int lat;
        logic [MSG_W-1:0] msg;
        int stalls = $urandom_range(0, 2);
        msg = {2'(op), 3'(x), 3'(y)};
        for (int s = 0; s < stalls; s++) begin
            @(negedge clock);
            read_en = 1'b0;
            read = 8'($urandom);
            @(negedge clock);
            check("retry_ack", 32'(read_ack), 32'd1);
            sync_ack();
        end
        exp_q.push_back(32'(model_apply(op, x, y)));
        @(negedge clock);
        read_en = 1'b1;
        read = msg;
        @(negedge clock);
        read_en = 1'b0;
        read = 8'($urandom);
        lat = 1;
        while (!read_ack && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 32'(lat), exp_q.pop_front());
    endtask

    task automatic check_status();
        check("revealed_count", 32'(revealed_count), 32'(m_rc));
        check("game_over", 32'(game_over), 32'(m_over));
        check("game_won", 32'(game_won), 32'(m_won));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_cell(input int x, input int y);
        int i = y*N + x;
        rd_x = 3'(x);
        rd_y = 3'(y);
        @(negedge clock);
        check("rd_cell", 32'(rd_cell), 32'({m_flag[i], m_rev[i], 4'(m_cnt[i])}));
        @(negedge clock);
        sync_ack();
    endtask

    task automatic do_cmd(input int op, input int x, input int y);
        send(op, x, y);
        check_status();
        if (op == 1 || op == 2) check_cell(x, y);
    endtask

    task automatic do_reset();
        int cyc, busy_cnt;
        reset = 1'b1;
        read_en = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_read_ack", 32'(read_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_game_won", 32'(game_won), 32'd0);
        check("rst_revealed", 32'(revealed_count), 32'd0);
        check("rst_rd_cell", 32'(rd_cell), 32'd0);
        model_clear();
        reset = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!read_ack && cyc < 300) begin
            busy_cnt += int'(busy);
            @(negedge clock);
            cyc++;
        end
        check("first_ack_cycle", 32'(cyc), 32'(CELLS + 1));
        check("sweep_busy_cycles", 32'(busy_cnt), 32'(CELLS));
    endtask

    function automatic logic [CELLS-1:0] bit_at(input int x, input int y);
        logic [CELLS-1:0] b = '0;
        b[y*N + x] = 1'b1;
        return b;
    endfunction

    initial begin
        int order[$];
        int tmp, j, r, op;

        // reset with empty board
        do_reset();
        check_cell(3, 3);
        check_status();

        // three mines around (1,1)
        mine_map = bit_at(0, 0) | bit_at(1, 0) | bit_at(0, 1);
        do_cmd(3, 0, 0);
        do_cmd(1, 1, 1);
        check("cell_1_1_literal", 32'(rd_cell), 32'(6'b01_0011));

        // corner (7,7) with no wrap to (0,0)
        mine_map = bit_at(6, 6) | bit_at(0, 0);
        do_cmd(3, 0, 0);
        do_cmd(1, 7, 7);
        check("corner_count", 32'(rd_cell), 32'(6'b01_0001));

        // flag protects, unflag, then reveal; flag on a revealed cell does nothing
        do_cmd(2, 2, 2);
        do_cmd(1, 2, 2);
        check("flagged_stays", 32'(rd_cell), 32'(6'b10_0000));
        do_cmd(2, 2, 2);
        do_cmd(1, 2, 2);
        do_cmd(2, 7, 7);
        do_cmd(0, 5, 5);

        // mine reveal ends the game; later commands are discarded until CLEAR
        do_cmd(1, 6, 6);
        check("boom_over", 32'(game_over), 32'd1);
        do_cmd(1, 4, 4);
        check("discard_cell", 32'(rd_cell), 32'd0);
        do_cmd(2, 4, 4);
        do_cmd(3, 0, 0);
        check("clear_over", 32'(game_over), 32'd0);

        // single mine at (0,0): reveal the other 63 cells in random order
        mine_map = bit_at(0, 0);
        do_cmd(3, 0, 0);
        for (int i = 1; i < CELLS; i++) order.push_back(i);
        for (int i = CELLS - 2; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        foreach (order[i]) begin
            do_cmd(1, order[i] % N, order[i] / N);
            if ($urandom_range(0, 7) == 0) do_cmd(0, 0, 0);
        end
        check("won_final", 32'(game_won), 32'd1);
        check("won_count", 32'(revealed_count), 32'd63);

        // random boards and random command streams
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < CELLS; i++) mine_map[i] = ($urandom_range(0, 9) == 0);
            do_cmd(3, 0, 0);
            for (int c = 0; c < 40; c++) begin
                r = $urandom_range(0, 99);
                op = (r < 60) ? 1 : (r < 85) ? 2 : (r < 97) ? 0 : 3;
                do_cmd(op, $urandom_range(0, N-1), $urandom_range(0, N-1));
            end
        end

        // reset in the middle of a neighbour scan aborts the reveal
        mine_map = '0;
        do_cmd(3, 0, 0);
        @(negedge clock);
        read_en = 1'b1;
        read = {2'b01, 3'd5, 3'd5};
        @(negedge clock);
        read_en = 1'b0;
        repeat (4) @(negedge clock);
        do_reset();
        check_cell(5, 5);
        check_status();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
